// File: rtl/pacman_pkg.sv
// Shared maze definitions: one-hot headings, ghost mode encoding and the
// tile pitch used by both the ghost controllers and direction_flag.
package pacman_pkg;

    localparam int unsigned TILE_DEF = 12;

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_FRIGHT  = 2'd2
    } mode_e;

    // Opposite heading (L<->R, U<->D); an empty heading stays empty.
    function automatic logic [3:0] dir_rev(input logic [3:0] d);
        return {d[1], d[0], d[3], d[2]};
    endfunction

endpackage

// File: rtl/ghost_dir_pick.sv
// Junction heading choice: preferred axes toward (or away from) the target,
// then the fixed U,L,D,R fallback; reversing only when nothing else is open.
module ghost_dir_pick
    import pacman_pkg::*;
#(
    parameter int unsigned COORD_W = 9
) (
    input  logic signed [COORD_W:0] dx,
    input  logic signed [COORD_W:0] dy,
    input  logic                    open_l,
    input  logic                    open_u,
    input  logic                    open_r,
    input  logic                    open_d,
    input  logic [3:0]              cur_dir,
    input  logic                    frightened,
    output logic [3:0]              pick
);

    logic [COORD_W:0] adx, ady;
    logic [3:0]       h_pref, v_pref, open_v, rev;
    logic [5:0][3:0]  cand;
    logic             found;

    always_comb begin
        adx    = dx[COORD_W] ? -dx : dx;
        ady    = dy[COORD_W] ? -dy : dy;
        h_pref = '0;
        v_pref = '0;
        if (dx > 0)      h_pref = DIR_R;
        else if (dx < 0) h_pref = DIR_L;
        if (dy > 0)      v_pref = DIR_D;
        else if (dy < 0) v_pref = DIR_U;
        if (frightened) begin
            h_pref = dir_rev(h_pref);
            v_pref = dir_rev(v_pref);
        end
        cand[0] = (adx >= ady) ? h_pref : v_pref;
        cand[1] = (adx >= ady) ? v_pref : h_pref;
        cand[2] = DIR_U;
        cand[3] = DIR_L;
        cand[4] = DIR_D;
        cand[5] = DIR_R;
        open_v  = {open_l, open_u, open_r, open_d};
        rev     = dir_rev(cur_dir);
        pick    = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (!found && |(cand[i] & open_v) && cand[i] != rev) begin
                pick  = cand[i];
                found = 1'b1;
            end
        end
        if (!found && |(rev & open_v)) pick = rev;
    end

endmodule

// File: rtl/ghost_ai.sv
// Single-ghost controller: pixel stepping on the tile grid, junction decisions
// toward a mode-dependent target, and the SCATTER/CHASE/FRIGHTENED timer.
module ghost_ai
    import pacman_pkg::*;
#(
    parameter int unsigned COORD_W   = 9,
    parameter int unsigned TILE      = TILE_DEF,
    parameter int unsigned START_X   = 84,
    parameter int unsigned START_Y   = 96,
    parameter int unsigned CORNER_X  = 0,
    parameter int unsigned CORNER_Y  = 0,
    parameter int unsigned MOVE_DIV  = 4,
    parameter int unsigned SCATTER_T = 420,
    parameter int unsigned CHASE_T   = 1200,
    parameter int unsigned FRIGHT_T  = 360
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    input  logic               fright_req,
    input  logic               open_l,
    input  logic               open_u,
    input  logic               open_r,
    input  logic               open_d,
    output logic [COORD_W-1:0] m_x,
    output logic [COORD_W-1:0] m_y,
    output logic [3:0]         dir,
    output logic [1:0]         mode,
    output logic               step
);

    localparam int unsigned PRE_W = $clog2(MOVE_DIV + 1);
    localparam int unsigned SUB_W = $clog2(TILE);
    localparam int unsigned T_MAX = (SCATTER_T > CHASE_T)
        ? ((SCATTER_T > FRIGHT_T) ? SCATTER_T : FRIGHT_T)
        : ((CHASE_T > FRIGHT_T) ? CHASE_T : FRIGHT_T);
    localparam int unsigned TMR_W = $clog2(T_MAX + 1);

    logic [COORD_W-1:0]      x_q, x_d, y_q, y_d, tgt_x, tgt_y;
    logic [SUB_W-1:0]        fx_q, fx_d, fy_q, fy_d;
    logic [3:0]              dir_q, dir_d, open_v, pick, new_dir;
    mode_e                   mode_q, mode_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [TMR_W-1:0]        timer_q, timer_d, limit;
    logic                    half_q, half_d, pend_q, pend_d;
    logic                    tick, fright, centre, expire, mode_chg;
    logic                    can_move, at_edge, do_move;
    logic signed [COORD_W:0] dx, dy;

    assign tick   = rst_n && en && (presc_q == PRE_W'(MOVE_DIV - 1));
    assign fright = en && fright_req;
    assign centre = (fx_q == '0) && (fy_q == '0);
    assign open_v = {open_l, open_u, open_r, open_d};
    assign tgt_x  = (mode_q == MODE_SCATTER) ? COORD_W'(CORNER_X) : p_x;
    assign tgt_y  = (mode_q == MODE_SCATTER) ? COORD_W'(CORNER_Y) : p_y;
    assign dx     = $signed({1'b0, tgt_x}) - $signed({1'b0, x_q});
    assign dy     = $signed({1'b0, tgt_y}) - $signed({1'b0, y_q});

    ghost_dir_pick #(.COORD_W(COORD_W)) u_pick (
        .dx         (dx),
        .dy         (dy),
        .open_l     (open_l),
        .open_u     (open_u),
        .open_r     (open_r),
        .open_d     (open_d),
        .cur_dir    (dir_q),
        .frightened (mode_q == MODE_FRIGHT),
        .pick       (pick)
    );

    always_comb begin
        case (mode_q)
            MODE_CHASE:  limit = TMR_W'(CHASE_T);
            MODE_FRIGHT: limit = TMR_W'(FRIGHT_T);
            default:     limit = TMR_W'(SCATTER_T);
        endcase
    end

    assign expire = tick && (timer_q == limit - 1'b1);

    // A pending reversal overrides the junction decision; off-centre the corridor is committed.
    always_comb begin
        new_dir  = dir_q;
        can_move = 1'b1;
        if (pend_q) begin
            new_dir  = dir_rev(dir_q);
            can_move = !centre || |(new_dir & open_v);
        end else if (centre) begin
            if (pick == '0) can_move = 1'b0;
            else            new_dir  = pick;
        end
    end

    assign at_edge = (new_dir == DIR_L && x_q == '0) || (new_dir == DIR_U && y_q == '0) ||
                     (new_dir == DIR_R && x_q == '1) || (new_dir == DIR_D && y_q == '1);
    assign do_move = tick && can_move && !at_edge && (mode_q != MODE_FRIGHT || half_q);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        fx_d  = fx_q;
        fy_d  = fy_q;
        dir_d = tick ? new_dir : dir_q;
        if (do_move) begin
            case (new_dir)
                DIR_L: begin
                    x_d  = x_q - 1'b1;
                    fx_d = (fx_q == '0) ? SUB_W'(TILE - 1) : fx_q - 1'b1;
                end
                DIR_R: begin
                    x_d  = x_q + 1'b1;
                    fx_d = (fx_q == SUB_W'(TILE - 1)) ? '0 : fx_q + 1'b1;
                end
                DIR_U: begin
                    y_d  = y_q - 1'b1;
                    fy_d = (fy_q == '0) ? SUB_W'(TILE - 1) : fy_q - 1'b1;
                end
                DIR_D: begin
                    y_d  = y_q + 1'b1;
                    fy_d = (fy_q == SUB_W'(TILE - 1)) ? '0 : fy_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A fright request while already frightened only reloads the timer; it is not a mode entry.
    always_comb begin
        presc_d  = presc_q;
        timer_d  = timer_q;
        half_d   = half_q;
        pend_d   = pend_q;
        mode_d   = mode_q;
        mode_chg = 1'b0;
        if (en) presc_d = (presc_q == PRE_W'(MOVE_DIV - 1)) ? '0 : presc_q + 1'b1;
        if (tick) begin
            timer_d = timer_q + 1'b1;
            half_d  = ~half_q;
            pend_d  = 1'b0;
        end
        if (fright) begin
            timer_d = '0;
            if (mode_q != MODE_FRIGHT) begin
                mode_d   = MODE_FRIGHT;
                mode_chg = 1'b1;
            end
        end else if (expire) begin
            timer_d  = '0;
            mode_d   = (mode_q == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
            mode_chg = 1'b1;
        end
        if (mode_chg) begin
            pend_d = 1'b1;
            half_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= COORD_W'(START_X);
            y_q     <= COORD_W'(START_Y);
            fx_q    <= '0;
            fy_q    <= '0;
            dir_q   <= DIR_U;
            mode_q  <= MODE_SCATTER;
            presc_q <= '0;
            timer_q <= '0;
            half_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            half_q  <= half_d;
            pend_q  <= pend_d;
        end
    end

    assign m_x  = x_q;
    assign m_y  = y_q;
    assign dir  = dir_q;
    assign mode = mode_q;
    assign step = tick;

endmodule

// File: tb/tb_ghost_ai.sv
// Scoreboard bench for ghost_ai: a behavioural ghost model predicts the state
// after every move tick; a monitor pops a prediction for each step pulse.
module tb_ghost_ai;

    localparam int COORD_W   = 9;
    localparam int TILE      = 12;
    localparam int START_X   = 84;
    localparam int START_Y   = 96;
    localparam int CORNER_X  = 0;
    localparam int CORNER_Y  = 0;
    localparam int MOVE_DIV  = 2;
    localparam int SCATTER_T = 300;
    localparam int CHASE_T   = 150;
    localparam int FRIGHT_T  = 40;
    localparam int MAXC      = (1 << COORD_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n, en, fright_req;
    logic               open_l, open_u, open_r, open_d;
    logic [COORD_W-1:0] p_x, p_y, m_x, m_y;
    logic [3:0]         dir;
    logic [1:0]         mode;
    logic               step;

    always #5 clk = ~clk;

    ghost_ai #(
        .COORD_W(COORD_W), .TILE(TILE), .START_X(START_X), .START_Y(START_Y),
        .CORNER_X(CORNER_X), .CORNER_Y(CORNER_Y), .MOVE_DIV(MOVE_DIV),
        .SCATTER_T(SCATTER_T), .CHASE_T(CHASE_T), .FRIGHT_T(FRIGHT_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .p_x(p_x), .p_y(p_y),
        .fright_req(fright_req), .open_l(open_l), .open_u(open_u),
        .open_r(open_r), .open_d(open_d), .m_x(m_x), .m_y(m_y),
        .dir(dir), .mode(mode), .step(step)
    );

    typedef struct { int x; int y; int d; int mode; } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Model state: heading as 0=L 1=U 2=R 3=D, mode 0/1/2, ticks remaining in mode.
    int mx, my, md, mmode, mpresc, mrem, mfticks;
    bit mpend;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mode_len(input int m);
        if (m == 1) return CHASE_T;
        if (m == 2) return FRIGHT_T;
        return SCATTER_T;
    endfunction

    function automatic bit is_open(input int d);
        case (d)
            0: return open_l;
            1: return open_u;
            2: return open_r;
            default: return open_d;
        endcase
    endfunction

    function automatic int model_pick(input int tx, input int ty, input bit fr);
        int dx, dy, h, v, rv;
        int c[6];
        dx = tx - mx;
        dy = ty - my;
        h = -1;
        v = -1;
        if (dx > 0) h = 2; else if (dx < 0) h = 0;
        if (dy > 0) v = 3; else if (dy < 0) v = 1;
        if (fr) begin
            if (h >= 0) h = (h + 2) % 4;
            if (v >= 0) v = (v + 2) % 4;
        end
        if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) c = '{h, v, 1, 0, 3, 2};
        else c = '{v, h, 1, 0, 3, 2};
        rv = (md + 2) % 4;
        foreach (c[i]) if (c[i] >= 0 && is_open(c[i]) && c[i] != rv) return c[i];
        if (is_open(rv)) return rv;
        return -1;
    endfunction

    task automatic model_reset();
        mx = START_X; my = START_Y; md = 1; mmode = 0;
        mpresc = 0; mrem = SCATTER_T; mfticks = 0; mpend = 0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs just driven.
    task automatic model_cycle();
        bit tk, can, chg, ctr;
        int nd, nx, ny, tx, ty, nmode;
        exp_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) return;
        tk = (mpresc == MOVE_DIV - 1);
        mpresc = tk ? 0 : mpresc + 1;
        chg = 0;
        nmode = mmode;
        if (tk) begin
            can = 1;
            nd = md;
            ctr = (mx % TILE == 0) && (my % TILE == 0);
            if (mpend) begin
                nd = (md + 2) % 4;
                mpend = 0;
                if (ctr) can = is_open(nd);
            end else if (ctr) begin
                tx = (mmode == 0) ? CORNER_X : int'(p_x);
                ty = (mmode == 0) ? CORNER_Y : int'(p_y);
                nd = model_pick(tx, ty, mmode == 2);
                if (nd < 0) begin
                    nd = md;
                    can = 0;
                end
            end
            md = nd;
            nx = mx + ((md == 2) ? 1 : 0) - ((md == 0) ? 1 : 0);
            ny = my + ((md == 3) ? 1 : 0) - ((md == 1) ? 1 : 0);
            if (mmode == 2 && (mfticks % 2) == 0) can = 0;
            if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) can = 0;
            if (can) begin
                mx = nx;
                my = ny;
            end
            mfticks++;
            mrem--;
        end
        if (fright_req) begin
            mrem = FRIGHT_T;
            if (mmode != 2) begin
                nmode = 2;
                chg = 1;
            end
        end else if (tk && mrem == 0) begin
            nmode = (mmode == 0) ? 1 : 0;
            mrem = mode_len(nmode);
            chg = 1;
        end
        if (chg) begin
            mmode = nmode;
            mpend = 1;
            mfticks = 0;
        end
        if (tk) begin
            e.x = mx; e.y = my; e.d = 8 >> md; e.mode = mmode;
            sbq.push_back(e);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit fr,
                         input int px, input int py, input bit [3:0] op);
        @(negedge clk);
        rst_n = r;
        en = e;
        fright_req = fr;
        p_x = COORD_W'(px);
        p_y = COORD_W'(py);
        {open_l, open_u, open_r, open_d} = op;
        model_cycle();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_x"}, m_x, mx);
        check({tag, "_y"}, m_y, my);
        check({tag, "_dir"}, dir, 8 >> md);
        check({tag, "_mode"}, mode, mmode);
        check({tag, "_step"}, step, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (step === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL step_extra: got step=1 expected no tick");
                end else begin
                    e = sbq.pop_front();
                    @(posedge clk);
                    #1;
                    check("tick_x", m_x, e.x);
                    check("tick_y", m_y, e.y);
                    check("tick_dir", dir, e.d);
                    check("tick_mode", mode, e.mode);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit fr, en_r;
        bit [3:0] op;
        int px, py, n;
        rst_n = 1'b0; en = 1'b0; fright_req = 1'b0;
        p_x = '0; p_y = '0;
        {open_l, open_u, open_r, open_d} = 4'b0000;
        model_reset();

        repeat (3) drive(0, 1, 0, 120, 84, 4'b0000);
        @(posedge clk);
        #1;
        check_reset("reset");

        // Straight corridor upward, then open field toward the scatter corner.
        repeat (30) drive(1, 1, 0, 120, 84, 4'b0100);
        repeat (500) drive(1, 1, 0, 300, 300, 4'b1111);

        px = 120;
        py = 84;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                px = $urandom_range(0, MAXC);
                py = $urandom_range(0, MAXC);
            end
            op   = 4'($urandom_range(0, 15));
            en_r = ($urandom_range(0, 15) != 0);
            fr   = ($urandom_range(0, 79) == 0);
            if (en_r && mrem == 1 && mpresc == MOVE_DIV - 1 && $urandom_range(0, 1) == 1) fr = 1;
            drive(($urandom_range(0, 999) != 0), en_r, fr, px, py, op);
        end

        drive(1, 1, 1, px, py, 4'b1111);
        @(posedge clk);
        #1;
        check("fright_mode", mode, 2);

        n = 0;
        while (!(mmode == 0 && mrem == 1 && mpresc == MOVE_DIV - 1) && n < 3000) begin
            drive(1, 1, 0, px, py, 4'($urandom_range(0, 15)));
            n++;
        end
        check("expiry_reached", (n < 3000) ? 1 : 0, 1);
        drive(1, 1, 1, px, py, 4'b1111);
        @(posedge clk);
        #1;
        check("fright_vs_expiry", mode, 2);
        repeat (6) drive(1, 1, 0, px, py, 4'b1111);

        drive(0, 1'($urandom_range(0, 1)), 0, px, py, 4'b1111);
        @(posedge clk);
        #1;
        check_reset("midrun_reset");

        repeat (4) drive(1, 0, 0, px, py, 4'b1111);
        @(posedge clk);
        #1;
        check("queue_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
